// File: rtl/my_alu_md_pkg.sv
// my_alu_md_pkg
// Shared definitions for the multi-cycle multiply/divide unit.
//   - MD_* operation codes (code 7 is reserved and yields 0)
//   - md_state_t FSM state encoding
//   - helpers classifying an op as signed and/or divide-type
package my_alu_md_pkg;

    localparam logic [2:0] MD_MUL   = 3'd0;
    localparam logic [2:0] MD_MULH  = 3'd1;
    localparam logic [2:0] MD_MULHU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MOD   = 3'd5;
    localparam logic [2:0] MD_MODU  = 3'd6;

    typedef enum logic [1:0] {
        MDS_IDLE = 2'd0,
        MDS_CALC = 2'd1,
        MDS_FIX  = 2'd2,
        MDS_DONE = 2'd3
    } md_state_t;

    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_MOD);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU) || (op == MD_MOD) || (op == MD_MODU);
    endfunction

endpackage

// File: rtl/my_md_iter.sv
// my_md_iter
// Combinational single-iteration datapath shared by multiply and divide.
//   acc     : upper accumulator (partial product high half / partial remainder)
//   sr      : shift register (multiplier bits / dividend bits becoming quotient)
//   mag     : operand magnitude (multiplicand / divisor)
//   is_div  : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_nxt, sr_nxt : state after one iteration
module my_md_iter #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] sr,
    input  logic [WIDTH-1:0] mag,
    input  logic             is_div,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] sr_nxt
);

    logic [WIDTH-1:0] add_in;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    // Multiply: add multiplicand when the current multiplier LSB is set, then
    // shift {carry, acc, sr} right; product bits accumulate from the top of sr.
    assign add_in = sr[0] ? mag : '0;
    assign sum    = {1'b0, acc} + {1'b0, add_in};

    // Divide: shift the next dividend bit into the partial remainder and try
    // to subtract. A set top bit of diff is the borrow (remainder < divisor).
    assign rem_sh = {acc, sr[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, mag};

    always_comb begin
        acc_nxt = sum[WIDTH:1];
        sr_nxt  = {sum[0], sr[WIDTH-1:1]};
        if (is_div) begin
            if (diff[WIDTH]) begin
                acc_nxt = rem_sh[WIDTH-1:0];
                sr_nxt  = {sr[WIDTH-2:0], 1'b0};
            end else begin
                acc_nxt = diff[WIDTH-1:0];
                sr_nxt  = {sr[WIDTH-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/my_alu_md.sv
// my_alu_md
// Iterative multiply/divide unit (one bit per cycle) with valid/ready handshake.
// WIDTH must be >= 4 and even.
//   clk, rst_n      : clock, async active-low reset
//   flush           : synchronous abort of in-flight or held result
//   in_valid/ready  : operand handshake; md_op, A (right operand), B (left operand)
//   out_valid/ready : result handshake; C holds the result while out_valid
//
// state    | meaning
// ---------+-----------------------------------------------------------
// MDS_IDLE | waiting for operands
// MDS_CALC | WIDTH iterations of shift-add / restoring divide
// MDS_FIX  | sign correction and result select, C registered
// MDS_DONE | C valid, held until out_ready (back-to-back accept allowed)
module my_alu_md
    import my_alu_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C
);

    localparam int CW = $clog2(WIDTH);

    md_state_t          state;
    logic [2:0]         op;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   sr;
    logic [WIDTH-1:0]   mag;
    logic               sign_a;
    logic               sign_b;

    logic               accept;
    logic               sgn_op;
    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]   sr_nxt;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   res;

    assign in_ready = (state == MDS_IDLE) | ((state == MDS_DONE) & out_ready);
    assign accept   = in_valid & in_ready;

    assign sgn_op = md_is_signed(md_op);
    assign neg_a  = sgn_op & A[WIDTH-1];
    assign neg_b  = sgn_op & B[WIDTH-1];
    assign abs_a  = neg_a ? -A : A;
    assign abs_b  = neg_b ? -B : B;

    my_md_iter #(.WIDTH(WIDTH)) u_iter (
        .acc     (acc),
        .sr      (sr),
        .mag     (mag),
        .is_div  (md_is_div(op)),
        .acc_nxt (acc_nxt),
        .sr_nxt  (sr_nxt)
    );

    // Sign correction. A zero divisor leaves the all-ones quotient untouched;
    // the remainder is still re-signed so that it comes back equal to B.
    always_comb begin
        prod     = {acc, sr};
        prod_fix = (sign_a ^ sign_b) ? -prod : prod;
        quo_fix  = ((sign_a ^ sign_b) && (mag != '0)) ? -sr : sr;
        rem_fix  = sign_b ? -acc : acc;
        res      = '0;
        case (op)
            MD_MUL:           res = prod_fix[WIDTH-1:0];
            MD_MULH,
            MD_MULHU:         res = prod_fix[2*WIDTH-1:WIDTH];
            MD_DIV,
            MD_DIVU:          res = quo_fix;
            MD_MOD,
            MD_MODU:          res = rem_fix;
            default:          res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= MDS_IDLE;
            op        <= '0;
            cnt       <= '0;
            acc       <= '0;
            sr        <= '0;
            mag       <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            out_valid <= 1'b0;
            C         <= '0;
        end else if (flush) begin
            state     <= MDS_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                MDS_CALC: begin
                    acc <= acc_nxt;
                    sr  <= sr_nxt;
                    if (cnt == '0) begin
                        state <= MDS_FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                MDS_FIX: begin
                    C         <= res;
                    out_valid <= 1'b1;
                    state     <= MDS_DONE;
                end
                MDS_IDLE,
                MDS_DONE: begin
                    if ((state == MDS_DONE) && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= MDS_IDLE;
                    end
                    // Accept overrides the DONE->IDLE move for back-to-back ops.
                    if (accept) begin
                        op     <= md_op;
                        sign_a <= neg_a;
                        sign_b <= neg_b;
                        acc    <= '0;
                        cnt    <= CW'(WIDTH - 1);
                        // Multiply iterates over A's bits; divide over B's bits.
                        if (md_is_div(md_op)) begin
                            sr  <= abs_b;
                            mag <= abs_a;
                        end else begin
                            sr  <= abs_a;
                            mag <= abs_b;
                        end
                        state <= MDS_CALC;
                    end
                end
                default: state <= MDS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_my_alu_md.sv
// tb_my_alu_md
// Scoreboard bench for my_alu_md at WIDTH=32 (directed + random) and
// WIDTH=8 (random). Expected results are queued at accept and popped when
// the consumer takes C; out_valid rise latency is checked per op.
module tb_my_alu_md;
    import my_alu_md_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush;
    logic        iv32, rdy32, ov32, ordy32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, c32;
    logic        iv8, rdy8, ov8, ordy8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, c8;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic        rnd_rdy = 1'b0;
    logic        ov32_q = 1'b0;
    logic        ov8_q = 1'b0;
    logic [31:0] q32[$];
    logic [31:0] q8[$];
    int          lat32[$];
    int          lat8[$];

    my_alu_md #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv32), .in_ready(rdy32),
        .md_op(op32), .A(a32), .B(b32), .out_valid(ov32), .out_ready(ordy32), .C(c32)
    );

    my_alu_md #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv8), .in_ready(rdy8),
        .md_op(op8), .A(a8), .B(b8), .out_valid(ov8), .out_ready(ordy8), .C(c8)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural reference: B is the left operand, A the right one.
    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] b,
                                           input logic [31:0] a, input int w);
        longint unsigned m, ua, ub;
        longint          sa, sb, r;
        m  = (64'd1 << w) - 64'd1;
        ua = {32'd0, a} & m;
        ub = {32'd0, b} & m;
        sa = ua[w-1] ? longint'(ua) - longint'(m) - 64'sd1 : longint'(ua);
        sb = ub[w-1] ? longint'(ub) - longint'(m) - 64'sd1 : longint'(ub);
        case (op)
            3'd0:    r = sa * sb;
            3'd1:    r = (sa * sb) >>> w;
            3'd2:    r = longint'((ua * ub) >> w);
            3'd3:    r = (ua == 0) ? longint'(m) : sb / sa;
            3'd4:    r = (ua == 0) ? longint'(m) : longint'(ub / ua);
            3'd5:    r = (ua == 0) ? sb : sb % sa;
            3'd6:    r = (ua == 0) ? longint'(ub) : longint'(ub % ua);
            default: r = 0;
        endcase
        return 32'(r & longint'(m));
    endfunction

    function automatic logic [31:0] pick(input logic [31:0] m);
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return m;
            3:       return (m >> 1) + 32'd1;
            4:       return m >> 1;
            5:       return m - 32'd6;
            default: return $urandom & m;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n && !flush) begin
            if (ov32 && !ov32_q) begin
                if (lat32.size() > 0) check("lat32", cyc - lat32.pop_front(), 33);
                else check("spurious_ov32", 32'd1, 32'd0);
            end
            if (ov32 && ordy32) begin
                if (q32.size() > 0) check("res32", c32, q32.pop_front());
                else check("extra_res32", 32'd1, 32'd0);
            end
            if (ov8 && !ov8_q) begin
                if (lat8.size() > 0) check("lat8", cyc - lat8.pop_front(), 9);
                else check("spurious_ov8", 32'd1, 32'd0);
            end
            if (ov8 && ordy8) begin
                if (q8.size() > 0) check("res8", 32'(c8), q8.pop_front());
                else check("extra_res8", 32'd1, 32'd0);
            end
        end
        ov32_q <= ov32;
        ov8_q  <= ov8;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_rdy) begin
            ordy32 = 1'($urandom_range(0, 1));
            ordy8  = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic issue32(input logic [2:0] op, input logic [31:0] b, input logic [31:0] a,
                           input logic [31:0] exp);
        int t = 0;
        op32 = op; b32 = b; a32 = a; iv32 = 1'b1;
        #1;
        while (!rdy32 && t < 200) begin tick(); t++; end
        if (!rdy32) begin
            check("accept32_timeout", 32'd0, 32'd1);
            iv32 = 1'b0;
            return;
        end
        q32.push_back(exp);
        lat32.push_back(cyc + 1);
        tick();
        iv32 = 1'b0;
        op32 = 3'($urandom); b32 = $urandom; a32 = $urandom;
    endtask

    task automatic issue8(input logic [2:0] op, input logic [7:0] b, input logic [7:0] a,
                          input logic [31:0] exp);
        int t = 0;
        op8 = op; b8 = b; a8 = a; iv8 = 1'b1;
        #1;
        while (!rdy8 && t < 200) begin tick(); t++; end
        if (!rdy8) begin
            check("accept8_timeout", 32'd0, 32'd1);
            iv8 = 1'b0;
            return;
        end
        q8.push_back(exp);
        lat8.push_back(cyc + 1);
        tick();
        iv8 = 1'b0;
        op8 = 3'($urandom); b8 = 8'($urandom); a8 = 8'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while ((q32.size() != 0 || q8.size() != 0) && t < 500) begin tick(); t++; end
        check("drain32", 32'(q32.size()), 32'd0);
        check("drain8", 32'(q8.size()), 32'd0);
    endtask

    task automatic wait_ov32();
        int t = 0;
        while (!ov32 && t < 100) begin tick(); t++; end
        check("ov32_seen", 32'(ov32), 32'd1);
    endtask

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] b;
        logic [31:0] a;
        logic [31:0] exp;
    } vec_t;

    localparam int NDIR = 15;
    localparam vec_t DIR [NDIR] = '{
        '{MD_MUL,   32'd6,         32'd7,         32'h0000002A},
        '{MD_MULH,  32'h80000000,  32'd2,         32'hFFFFFFFF},
        '{MD_MULHU, 32'h80000000,  32'd2,         32'h00000001},
        '{MD_DIV,   32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD},
        '{MD_MOD,   32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF},
        '{MD_DIVU,  32'hFFFFFFF9,  32'd2,         32'h7FFFFFFC},
        '{MD_MODU,  32'hFFFFFFF9,  32'd2,         32'h00000001},
        '{MD_DIV,   32'd5,         32'd0,         32'hFFFFFFFF},
        '{MD_MOD,   32'd5,         32'd0,         32'h00000005},
        '{MD_DIV,   32'h80000000,  32'hFFFFFFFF,  32'h80000000},
        '{MD_MOD,   32'h80000000,  32'hFFFFFFFF,  32'h00000000},
        '{3'd7,     32'd1234,      32'd5678,      32'h00000000},
        '{MD_DIV,   32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF},
        '{MD_MOD,   32'hFFFFFFFB,  32'd0,         32'hFFFFFFFB},
        '{MD_MUL,   32'hFFFFFFFD,  32'd5,         32'hFFFFFFF1}
    };

    initial begin
        logic [31:0] c_hold;
        logic [31:0] e;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          n_ov;

        rst_n = 1'b0; flush = 1'b0;
        iv32 = 1'b0; ordy32 = 1'b1; op32 = '0; a32 = '0; b32 = '0;
        iv8 = 1'b0;  ordy8 = 1'b1;  op8 = '0;  a8 = '0;  b8 = '0;
        repeat (3) tick();
        check("rst_ov32", 32'(ov32), 32'd0);
        check("rst_c32", c32, 32'd0);
        check("rst_rdy32", 32'(rdy32), 32'd1);
        rst_n = 1'b1;
        tick();
        check("rel_rdy32", 32'(rdy32), 32'd1);

        // Directed ops, back-to-back with out_ready high.
        for (int i = 0; i < NDIR; i++) issue32(DIR[i].op, DIR[i].b, DIR[i].a, DIR[i].exp);
        drain();

        // Backpressure: result held, no accept, then take + accept on one edge.
        ordy32 = 1'b0;
        issue32(MD_MUL, 32'd123, 32'd456, 32'd56088);
        wait_ov32();
        c_hold = c32;
        repeat (5) begin
            tick();
            check("bp_c_stable", c32, c_hold);
            check("bp_in_ready", 32'(rdy32), 32'd0);
            check("bp_out_valid", 32'(ov32), 32'd1);
        end
        ordy32 = 1'b1;
        issue32(MD_DIVU, 32'd1000, 32'd7, 32'd142);
        drain();

        // Flush at CALC cycle 10, then a flush colliding with an accept.
        c_hold = c32;
        issue32(MD_MUL, 32'd3, 32'd5, 32'd15);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        q32.delete(); lat32.delete();
        check("flush_calc_rdy", 32'(rdy32), 32'd1);
        op32 = MD_MUL; b32 = 32'd9; a32 = 32'd9; iv32 = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; iv32 = 1'b0;
        check("flush_acc_rdy", 32'(rdy32), 32'd1);
        n_ov = 0;
        repeat (45) begin tick(); if (ov32) n_ov++; end
        check("flush_no_ov", 32'(n_ov), 32'd0);
        check("flush_c_kept", c32, c_hold);

        // Flush while a result is held in DONE.
        ordy32 = 1'b0;
        issue32(MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        wait_ov32();
        check("done_val", c32, 32'hFFFFFFFE);
        c_hold = c32;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        q32.delete(); lat32.delete();
        check("fd_ov_drop", 32'(ov32), 32'd0);
        check("fd_c_kept", c32, c_hold);
        check("fd_idle", 32'(rdy32), 32'd1);
        ordy32 = 1'b1;

        // Async reset mid-CALC.
        issue32(MD_DIV, 32'd100, 32'd3, 32'd33);
        repeat (19) tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_c", c32, 32'd0);
        check("rst_mid_ov", 32'(ov32), 32'd0);
        check("rst_mid_rdy", 32'(rdy32), 32'd1);
        q32.delete(); lat32.delete();
        tick();
        rst_n = 1'b1;
        tick();
        issue32(MD_MOD, 32'd100, 32'd3, 32'd1);
        drain();

        // Random sweep on both widths with random out_ready.
        rnd_rdy = 1'b1;
        fork
            begin
                for (int i = 0; i < 250; i++) begin
                    rop = 3'($urandom_range(0, 7));
                    rb  = pick(32'hFFFFFFFF);
                    ra  = pick(32'hFFFFFFFF);
                    e   = ref_md(rop, rb, ra, 32);
                    issue32(rop, rb, ra, e);
                end
            end
            begin
                for (int j = 0; j < 400; j++) begin
                    logic [2:0]  op_r;
                    logic [31:0] a_r, b_r, e_r;
                    op_r = 3'($urandom_range(0, 7));
                    b_r  = pick(32'h000000FF);
                    a_r  = pick(32'h000000FF);
                    e_r  = ref_md(op_r, b_r, a_r, 8);
                    issue8(op_r, b_r[7:0], a_r[7:0], e_r);
                end
            end
        join
        @(posedge clk);
        #2;
        rnd_rdy = 1'b0;
        ordy32 = 1'b1;
        ordy8 = 1'b1;
        tick();
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
